// File: rtl/temp_sampler_if.sv
// Signal bundle between temp_sampler, the serial ADC and the threshold controller.
// The sampler holds the master side; the ADC/consumer side holds the slave side.
interface temp_sampler_if;
  logic       en;
  logic       adc_sdo;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] reading;
  logic       reading_valid;

  modport master (
    input  en,
    input  adc_sdo,
    output adc_cs_n,
    output adc_sclk,
    output reading,
    output reading_valid
  );

  modport slave (
    output en,
    output adc_sdo,
    input  adc_cs_n,
    input  adc_sclk,
    input  reading,
    input  reading_valid
  );
endinterface

// File: rtl/temp_sampler.sv
// Serial temperature ADC reader: frames 8-bit conversions and publishes them.
// Define TEMP_SAMPLER_AVG_EN to publish a 4-sample moving average instead.
module temp_sampler #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 16
) (
  input  logic          clk,
  input  logic          reset,
  temp_sampler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    PUBLISH
  } state_t;

  localparam int CMAX = (SAMPLE_GAP > CLK_DIV) ? SAMPLE_GAP : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] GAP_END = CW'(SAMPLE_GAP - 1);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          hi, hi_n;
  logic          take, pub;
  logic          cs_n_d, sclk_d;
  logic          cs_n_q, sclk_q;
  logic [7:0]    sample;
  logic [7:0]    reading_q;
  logic          valid_q;

  // Sequencer: gap, chip-select setup, 8 sclk periods, hold, publish.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    hi_n    = hi;
    take    = 1'b0;
    pub     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt == GAP_END) begin
          if (bus.en) begin
            state_n = SETUP;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      SETUP: begin
        if (cnt == DIV_END) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = 3'd7;
          hi_n    = 1'b0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      SHIFT: begin
        if (cnt == DIV_END) begin
          cnt_n = '0;
          if (!hi) begin
            hi_n = 1'b1;
            take = 1'b1;
          end else if (bit_cnt == 3'd0) begin
            hi_n    = 1'b0;
            state_n = HOLD;
          end else begin
            hi_n  = 1'b0;
            bit_n = bit_cnt - 3'd1;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HOLD: begin
        if (cnt == DIV_END) begin
          state_n = PUBLISH;
          cnt_n   = '0;
          pub     = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PUBLISH: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    cs_n_d = !(state_n == SETUP || state_n == SHIFT ||
               state_n == HOLD);
    sclk_d = (state_n == SHIFT) && hi_n;
  end

  // State, counters and the registered ADC pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= 3'd7;
      hi      <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      hi      <= hi_n;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  // Capture sdo on the edge that raises sclk; MSB arrives first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= 8'h00;
    end else if (take) begin
      sample <= {sample[6:0], bus.adc_sdo};
    end
  end

`ifdef TEMP_SAMPLER_AVG_EN
  logic [3:0][7:0] hist;
  logic [9:0]      sum;
  logic [1:0]      warm;
  logic [9:0]      sum_new;

  assign sum_new = sum - {2'b00, hist[3]} + {2'b00, sample};

  // Moving average of the last four samples; silent until four are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      sum       <= 10'd0;
      warm      <= 2'd0;
      reading_q <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (pub) begin
        hist <= {hist[2:0], sample};
        sum  <= sum_new;
        if (warm == 2'd3) begin
          reading_q <= sum_new[9:2];
          valid_q   <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end
`else
  // Raw sample goes straight out on every frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reading_q <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= pub;
      if (pub) begin
        reading_q <= sample;
      end
    end
  end
`endif

  assign bus.adc_cs_n      = cs_n_q;
  assign bus.adc_sclk      = sclk_q;
  assign bus.reading       = reading_q;
  assign bus.reading_valid = valid_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: serial ADC models, pulse monitors and a
// frame-level reference model (raw or 4-sample average).
module tb_temp_sampler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;

  logic [7:0] fr [16];
  int nfr = 0;
  int exp_c [$];
  logic [7:0] exp_v [$];

  temp_sampler_if b0 ();
  temp_sampler_if b1 ();

  temp_sampler u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  temp_sampler #(
    .CLK_DIV    (1),
    .SAMPLE_GAP (1)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  assign b1.en = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ADC model 0: returns fr[] frame by frame, next bit after sclk falls.
  logic [7:0] cur0 = 8'h00;
  int bit0 = 7;
  int fidx0 = 0;
  logic lcs0 = 1'b1;
  logic lsc0 = 1'b0;
  always @(b0.adc_cs_n or b0.adc_sclk or reset) begin
    if (reset) begin
      fidx0 = 0;
      lcs0 = 1'b1;
    end else if (b0.adc_cs_n) begin
      lcs0 = 1'b1;
    end else if (lcs0) begin
      lcs0 = 1'b0;
      cur0 = (fidx0 < nfr) ? fr[fidx0] : 8'h00;
      fidx0++;
      bit0 = 7;
    end else if (lsc0 && !b0.adc_sclk && bit0 > 0) begin
      bit0--;
    end
    lsc0 = b0.adc_sclk;
    b0.adc_sdo = cur0[bit0];
  end

  // ADC model 1: always converts 0xA5.
  logic [7:0] cur1 = 8'hA5;
  int bit1 = 7;
  logic lcs1 = 1'b1;
  logic lsc1 = 1'b0;
  always @(b1.adc_cs_n or b1.adc_sclk or reset) begin
    if (reset || b1.adc_cs_n) begin
      lcs1 = 1'b1;
    end else if (lcs1) begin
      lcs1 = 1'b0;
      bit1 = 7;
    end else if (lsc1 && !b1.adc_sclk && bit1 > 0) begin
      bit1--;
    end
    lsc1 = b1.adc_sclk;
    b1.adc_sdo = cur1[bit1];
  end

  // Monitor 0: cs falls, sclk rises per frame, pulses, hold violations.
  int pc0 [$];
  logic [7:0] pv0 [$];
  int csf0 [$];
  int rq0 [$];
  int rise0 = 0;
  int dbl0 = 0;
  int held0 = 0;
  logic pcs0 = 1'b1;
  logic psc0 = 1'b0;
  logic pvl0 = 1'b0;
  logic [7:0] pr0 = 8'h00;
  always @(negedge clk) begin
    int c;
    if (reset) begin
      pc0.delete();
      pv0.delete();
      csf0.delete();
      rq0.delete();
      rise0 = 0;
      dbl0 = 0;
      held0 = 0;
      pcs0 = 1'b1;
      psc0 = 1'b0;
      pvl0 = 1'b0;
      pr0 = 8'h00;
    end else begin
      c = cyc - t0;
      if (pcs0 && !b0.adc_cs_n) begin
        csf0.push_back(c);
        rise0 = 0;
      end
      if (!pcs0 && b0.adc_cs_n) rq0.push_back(rise0);
      if (!psc0 && b0.adc_sclk) rise0++;
      if (b0.reading_valid) begin
        pc0.push_back(c);
        pv0.push_back(b0.reading);
        if (pvl0) dbl0++;
      end else if (b0.reading !== pr0) begin
        held0++;
      end
      pcs0 = b0.adc_cs_n;
      psc0 = b0.adc_sclk;
      pvl0 = b0.reading_valid;
      pr0 = b0.reading;
    end
  end

  // Monitor 1: pulses of the fast instance.
  int pc1 [$];
  logic [7:0] pv1 [$];
  always @(negedge clk) begin
    if (reset) begin
      pc1.delete();
      pv1.delete();
    end else if (b1.reading_valid) begin
      pc1.push_back(cyc - t0);
      pv1.push_back(b1.reading);
    end
  end

  // Reference: publish cycle and value of each frame from the frame list.
  function automatic void model(input int gap, input int div);
    int s;
    int per;
    per = gap + 18 * div + 1;
    exp_c.delete();
    exp_v.delete();
    for (int i = 0; i < nfr; i++) begin
`ifdef TEMP_SAMPLER_AVG_EN
      if (i >= 3) begin
        s = fr[i] + fr[i-1] + fr[i-2] + fr[i-3];
        exp_c.push_back(gap + 18 * div + i * per);
        exp_v.push_back(8'(s / 4));
      end
`else
      exp_c.push_back(gap + 18 * div + i * per);
      exp_v.push_back(fr[i]);
`endif
    end
  endfunction

  task automatic do_reset(input logic e);
    @(negedge clk);
    reset = 1'b1;
    b0.en = e;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_to(input int c);
    while (cyc - t0 < c) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (b0.adc_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_cs_n got=%b exp=1", b0.adc_cs_n);
    end
    checks++;
    if (b0.adc_sclk !== 1'b0) begin
      failures++;
      $display("FAIL rst_sclk got=%b exp=0", b0.adc_sclk);
    end
    checks++;
    if (b0.reading !== 8'h00) begin
      failures++;
      $display("FAIL rst_reading got=%h exp=00", b0.reading);
    end
    checks++;
    if (b0.reading_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", b0.reading_valid);
    end
    checks++;
    if (b1.adc_cs_n !== 1'b1 || b1.reading !== 8'h00) begin
      failures++;
      $display("FAIL rst_fast got=%b/%h exp=1/00",
               b1.adc_cs_n, b1.reading);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fixed;
    nfr = 5;
    for (int i = 0; i < 5; i++) fr[i] = 8'hC8;
    model(16, 4);
    do_reset(1'b1);
    wait_to(88 + 4 * 89 + 2);
    checks++;
    if (csf0.size() == 0 || csf0[0] !== 16) begin
      failures++;
      $display("FAIL fixed_first_cs got=%0d exp=16",
               csf0.size() ? csf0[0] : -1);
    end
    checks++;
    if (rq0.size() < 5) begin
      failures++;
      $display("FAIL fixed_frames got=%0d exp=5", rq0.size());
    end
    foreach (rq0[i]) begin
      checks++;
      if (rq0[i] !== 8) begin
        failures++;
        $display("FAIL fixed_sclk_rises%0d got=%0d exp=8", i, rq0[i]);
      end
    end
    checks++;
    if (pc0.size() != exp_c.size()) begin
      failures++;
      $display("FAIL fixed_pulse_count got=%0d exp=%0d",
               pc0.size(), exp_c.size());
    end
    foreach (exp_c[i]) if (i < pc0.size()) begin
      checks++;
      if (pc0[i] !== exp_c[i] || pv0[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL fixed_pulse%0d got=%h@%0d exp=%h@%0d",
                 i, pv0[i], pc0[i], exp_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_sequence;
    nfr = 5;
    fr[0] = 8'hF0;
    fr[1] = 8'hF1;
    fr[2] = 8'hBF;
    fr[3] = 8'($urandom);
    fr[4] = 8'($urandom);
    model(16, 4);
    do_reset(1'b1);
    wait_to(88 + 4 * 89 + 2);
    checks++;
    if (pc0.size() != exp_c.size()) begin
      failures++;
      $display("FAIL seq_pulse_count got=%0d exp=%0d",
               pc0.size(), exp_c.size());
    end
    foreach (exp_c[i]) if (i < pc0.size()) begin
      checks++;
      if (pc0[i] !== exp_c[i] || pv0[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL seq_pulse%0d got=%h@%0d exp=%h@%0d",
                 i, pv0[i], pc0[i], exp_v[i], exp_c[i]);
      end
    end
    checks++;
    if (held0 !== 0) begin
      failures++;
      $display("FAIL seq_hold got=%0d changes exp=0", held0);
    end
    checks++;
    if (dbl0 !== 0) begin
      failures++;
      $display("FAIL seq_double_valid got=%0d exp=0", dbl0);
    end
  endtask

  task automatic test_average;
    nfr = 5;
    for (int i = 0; i < 5; i++) fr[i] = 8'((i + 1) * 16);
    model(16, 4);
    do_reset(1'b1);
    wait_to(88 + 4 * 89 + 2);
    checks++;
    if (pc0.size() != exp_c.size()) begin
      failures++;
      $display("FAIL avg_pulse_count got=%0d exp=%0d",
               pc0.size(), exp_c.size());
    end
    foreach (exp_c[i]) if (i < pc0.size()) begin
      checks++;
      if (pc0[i] !== exp_c[i] || pv0[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL avg_pulse%0d got=%h@%0d exp=%h@%0d",
                 i, pv0[i], pc0[i], exp_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_random;
    nfr = 7;
    for (int i = 0; i < 7; i++) fr[i] = 8'($urandom);
    model(16, 4);
    do_reset(1'b1);
    wait_to(88 + 6 * 89 + 2);
    checks++;
    if (pc0.size() != exp_c.size()) begin
      failures++;
      $display("FAIL rand_pulse_count got=%0d exp=%0d",
               pc0.size(), exp_c.size());
    end
    foreach (exp_c[i]) if (i < pc0.size()) begin
      checks++;
      if (pc0[i] !== exp_c[i] || pv0[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL rand_pulse%0d got=%h@%0d exp=%h@%0d",
                 i, pv0[i], pc0[i], exp_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_enable;
    int bad;
    int c_en;
    bad = 0;
    nfr = 1;
    fr[0] = 8'h3C;
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b0.adc_cs_n !== 1'b1 || b0.adc_sclk !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || csf0.size() !== 0) begin
      failures++;
      $display("FAIL en_idle got=%0d active cycles exp=0", bad);
    end
    b0.en = 1'b1;
    c_en = cyc - t0;
    for (int i = 0; i < 40 && csf0.size() == 0; i++) @(negedge clk);
    checks++;
    if (csf0.size() == 0 || csf0[0] !== c_en + 1) begin
      failures++;
      $display("FAIL en_setup got=%0d exp=%0d",
               csf0.size() ? csf0[0] : -1, c_en + 1);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    nfr = 3;
    fr[0] = 8'h5A;
    fr[1] = 8'hE7;
    fr[2] = 8'h81;
    do_reset(1'b1);
    wait_to(227);
    checks++;
    if (b0.adc_sclk !== 1'b1 || b0.adc_cs_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre got=%b/%b exp=1/0",
               b0.adc_sclk, b0.adc_cs_n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (b0.adc_cs_n !== 1'b1 || b0.adc_sclk !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got=%b/%b exp=1/0",
               b0.adc_cs_n, b0.adc_sclk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b0.reading !== 8'h00 || b0.reading_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mid_outputs got=%0d bad cycles exp=0", bad);
    end
    reset = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 40 && csf0.size() == 0; i++) @(negedge clk);
    checks++;
    if (csf0.size() == 0 || csf0[0] !== 16 || pc0.size() !== 0) begin
      failures++;
      $display("FAIL mid_restart got=%0d pulses=%0d exp=16 pulses=0",
               csf0.size() ? csf0[0] : -1, pc0.size());
    end
  endtask

  task automatic test_fast;
    nfr = 6;
    for (int i = 0; i < 6; i++) fr[i] = 8'hA5;
    model(1, 1);
    do_reset(1'b1);
    wait_to(19 + 5 * 20 + 2);
    checks++;
    if (pc1.size() != exp_c.size()) begin
      failures++;
      $display("FAIL fast_pulse_count got=%0d exp=%0d",
               pc1.size(), exp_c.size());
    end
    foreach (exp_c[i]) if (i < pc1.size()) begin
      checks++;
      if (pc1[i] !== exp_c[i] || pv1[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL fast_pulse%0d got=%h@%0d exp=%h@%0d",
                 i, pv1[i], pc1[i], exp_v[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.en = 1'b0;
    test_reset();
    test_fixed();
    test_sequence();
    test_average();
    test_random();
    test_enable();
    test_reset_mid();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
